// File: rtl/pdp8_mem_arb.sv
// pdp8_mem_arb: shares the single 32Kx12 main RAM between the CPU memory port
// and the I/O cycle-steal (DMA) port. The CPU owns the RAM by default. A pending
// DMA transfer takes the first idle CPU cycle. If the CPU keeps the RAM busy for
// MAX_WAIT cycles, the DMA transfer is forced and the CPU is stalled for that one
// cycle only.
module pdp8_mem_arb #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned WAIT_W   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] cpu_addr,
    input  logic [11:0] cpu_data_in,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [11:0] cpu_data_out,
    output logic        cpu_wait,
    input  logic        dma_read_req,
    input  logic        dma_write_req,
    input  logic [14:0] dma_ma,
    input  logic [11:0] dma_data_in,
    output logic        dma_done,
    output logic [11:0] dma_data_out,
    output logic [14:0] ram_addr,
    output logic [11:0] ram_data_out,
    output logic        ram_rd,
    output logic        ram_wr,
    input  logic [11:0] ram_data_in
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2,
        ST_REC  = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    state_t            state_q,     state_d;
    logic              op_wr_q,     op_wr_d;
    logic [14:0]       ma_q,        ma_d;
    logic [11:0]       wdata_q,     wdata_d;
    logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic              dma_done_q,  dma_done_d;
    logic [11:0]       dma_rdata_q, dma_rdata_d;
    logic [11:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_rd_q,    cpu_rd_d;

    logic              cpu_req_s;
    logic              wait_max_s;
    logic              grant_s;
    logic              dma_rd_done_s;

    assign cpu_req_s     = cpu_rd | cpu_wr;
    assign wait_max_s    = (wait_cnt_q == WAIT_MAX);
    assign dma_rd_done_s = (state_q == ST_DONE) && !op_wr_q;

    // DMA FSM next state: latch the request, wait for a slot, complete, recover.
    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        ma_d       = ma_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        dma_done_d = 1'b0;
        grant_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_write_req || dma_read_req) begin
                    // Write wins when both requests are raised together.
                    state_d    = ST_PEND;
                    op_wr_d    = dma_write_req;
                    ma_d       = dma_ma;
                    wdata_d    = dma_data_in;
                    wait_cnt_d = {WAIT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (!cpu_req_s || wait_max_s) begin
                    grant_s    = 1'b1;
                    dma_done_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    // Counter never passes WAIT_MAX: reaching it forces the grant.
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    state_d    = ST_PEND;
                end
            end
            ST_DONE: begin
                state_d = ST_REC;
            end
            ST_REC: begin
                // Requests are ignored here so the requester can drop its level.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM port steering: DMA in its granted cycle, CPU pass-through otherwise.
    always_comb begin
        ram_addr     = cpu_addr;
        ram_data_out = cpu_data_in;
        ram_rd       = 1'b0;
        ram_wr       = 1'b0;
        if (reset) begin
            ram_rd = 1'b0;
            ram_wr = 1'b0;
        end else if (grant_s) begin
            ram_addr     = ma_q;
            ram_data_out = wdata_q;
            ram_wr       = op_wr_q;
            ram_rd       = !op_wr_q;
        end else begin
            // A simultaneous read and write from the CPU is a write.
            ram_wr = cpu_wr;
            ram_rd = cpu_rd & ~cpu_wr;
        end
    end

    // Read-data capture: CPU and DMA each keep their own last-read word.
    always_comb begin
        cpu_rd_d    = cpu_rd & ~cpu_wr & ~grant_s;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        if (cpu_rd_q) begin
            cpu_rdata_d = ram_data_in;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        if (dma_rd_done_s) begin
            dma_rdata_d = ram_data_in;
        end else begin
            dma_rdata_d = dma_rdata_q;
        end
    end

    // State and data registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            ma_q        <= 15'd0;
            wdata_q     <= 12'd0;
            wait_cnt_q  <= {WAIT_W{1'b0}};
            dma_done_q  <= 1'b0;
            dma_rdata_q <= 12'd0;
            cpu_rdata_q <= 12'd0;
            cpu_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            ma_q        <= ma_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            dma_done_q  <= dma_done_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_rd_q    <= cpu_rd_d;
        end
    end

    // The RAM returns read data one cycle late, so in the cycle after a read the
    // live RAM word is shown; otherwise the held copy is shown.
    assign cpu_data_out = cpu_rd_q ? ram_data_in : cpu_rdata_q;
    assign dma_data_out = dma_rd_done_s ? ram_data_in : dma_rdata_q;
    assign dma_done     = dma_done_q;
    assign cpu_wait     = grant_s & cpu_req_s;

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// Self-checking bench for pdp8_mem_arb: directed test-plan steps followed by a
// randomized CPU/DMA traffic phase checked against a transaction-level model.
module tb_pdp8_mem_arb;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] cpu_addr;
    logic [11:0] cpu_data_in;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [11:0] cpu_data_out;
    logic        cpu_wait;
    logic        dma_read_req;
    logic        dma_write_req;
    logic [14:0] dma_ma;
    logic [11:0] dma_data_in;
    logic        dma_done;
    logic [11:0] dma_data_out;
    logic [14:0] ram_addr;
    logic [11:0] ram_data_out;
    logic        ram_rd;
    logic        ram_wr;
    logic [11:0] ram_data_in;

    // Synchronous RAM model with a backdoor load port.
    logic [11:0] mem [0:32767];
    logic [11:0] ram_rdata_r;
    logic        bd_we;
    logic [14:0] bd_addr;
    logic [11:0] bd_data;

    int vectors = 0;
    int errors  = 0;

    // Randomized-phase model state.
    logic [11:0] shadow [0:31];
    int          phase;
    int          blocked;
    logic        d_wr;
    logic [14:0] d_addr;
    logic [11:0] d_data;
    logic [11:0] last_dma;
    logic        prev_rd;
    logic [14:0] prev_addr;
    logic        hold;
    logic        creq;
    logic        exp_grant;
    logic        exp_wait;

    pdp8_mem_arb #(.MAX_WAIT(MAXW), .WAIT_W(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_data_out(cpu_data_out), .cpu_wait(cpu_wait),
        .dma_read_req(dma_read_req), .dma_write_req(dma_write_req), .dma_ma(dma_ma),
        .dma_data_in(dma_data_in), .dma_done(dma_done), .dma_data_out(dma_data_out),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_data_in(ram_data_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_wr) mem[ram_addr] <= ram_data_out;
        if (ram_rd) ram_rdata_r <= mem[ram_addr];
    end
    assign ram_data_in = ram_rdata_r;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0o, expected %0o", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic bd_load(input logic [14:0] a, input logic [11:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        step();
        bd_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        cpu_addr = 15'd0; cpu_data_in = 12'd0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        dma_read_req = 1'b0; dma_write_req = 1'b0; dma_ma = 15'd0; dma_data_in = 12'd0;
        bd_we = 1'b0; bd_addr = 15'd0; bd_data = 12'd0;
        step();

        // Reset state, with a CPU write pending to show strobes are held off.
        cpu_wr = 1'b1;
        settle();
        chk("reset ram_wr", ram_wr, 1'b0);
        chk("reset ram_rd", ram_rd, 1'b0);
        chk("reset cpu_wait", cpu_wait, 1'b0);
        chk("reset dma_done", dma_done, 1'b0);
        chk("reset dma_data_out", dma_data_out, 12'o0000);
        chk("reset cpu_data_out", cpu_data_out, 12'o0000);
        cpu_wr = 1'b0;

        bd_load(15'o00400, 12'o5555);
        bd_load(15'o00100, 12'o1111);
        bd_load(15'o00101, 12'o2222);
        bd_load(15'o00500, 12'o0000);
        for (int i = 0; i < 32; i++) begin
            shadow[i] = 12'($urandom);
            bd_load(15'(i), shadow[i]);
        end
        reset = 1'b0;
        step();

        // CPU only: write then read back.
        cpu_wr = 1'b1; cpu_addr = 15'o00200; cpu_data_in = 12'o1234;
        settle();
        chk("t1 wr ram_wr", ram_wr, 1'b1);
        chk("t1 wr ram_addr", ram_addr, 15'o00200);
        chk("t1 wr cpu_wait", cpu_wait, 1'b0);
        chk("t1 wr dma_done", dma_done, 1'b0);
        step();
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        settle();
        chk("t1 rd ram_rd", ram_rd, 1'b1);
        chk("t1 rd cpu_wait", cpu_wait, 1'b0);
        step();
        cpu_rd = 1'b0;
        settle();
        chk("t1 cpu_data_out", cpu_data_out, 12'o1234);
        chk("t1 dma_done", dma_done, 1'b0);
        step();
        chk("t1 cpu_data_out held", cpu_data_out, 12'o1234);

        // DMA write with CPU idle.
        dma_write_req = 1'b1; dma_ma = 15'o17777; dma_data_in = 12'o7070;
        settle();
        chk("t2 req dma_done", dma_done, 1'b0);
        chk("t2 req ram_wr", ram_wr, 1'b0);
        step();
        chk("t2 pend ram_wr", ram_wr, 1'b1);
        chk("t2 pend ram_addr", ram_addr, 15'o17777);
        chk("t2 pend ram_data_out", ram_data_out, 12'o7070);
        step();
        chk("t2 dma_done", dma_done, 1'b1);
        dma_write_req = 1'b0;
        step();
        chk("t2 rec dma_done", dma_done, 1'b0);
        cpu_rd = 1'b1; cpu_addr = 15'o17777;
        step();
        cpu_rd = 1'b0;
        settle();
        chk("t2 cpu readback", cpu_data_out, 12'o7070);
        step();

        // DMA read against continuous CPU reads: 4 blocked cycles then one stall.
        cpu_rd = 1'b1; cpu_addr = 15'o00200;
        dma_read_req = 1'b1; dma_ma = 15'o00400;
        settle();
        chk("t3 req cpu_wait", cpu_wait, 1'b0);
        step();
        for (int i = 0; i < MAXW; i++) begin
            chk("t3 blocked cpu_wait", cpu_wait, 1'b0);
            chk("t3 blocked ram_addr", ram_addr, 15'o00200);
            chk("t3 blocked cpu_data_out", cpu_data_out, 12'o1234);
            step();
        end
        chk("t3 forced cpu_wait", cpu_wait, 1'b1);
        chk("t3 forced ram_addr", ram_addr, 15'o00400);
        chk("t3 forced ram_rd", ram_rd, 1'b1);
        step();
        chk("t3 dma_done", dma_done, 1'b1);
        chk("t3 dma_data_out", dma_data_out, 12'o5555);
        chk("t3 done cpu_wait", cpu_wait, 1'b0);
        chk("t3 done ram_addr", ram_addr, 15'o00200);
        dma_read_req = 1'b0;
        step();
        chk("t3 cpu read after stall", cpu_data_out, 12'o1234);
        cpu_rd = 1'b0;
        step();
        chk("t3 dma_data_out held", dma_data_out, 12'o5555);

        // Interleave: CPU read then DMA read of the neighbouring word.
        cpu_rd = 1'b1; cpu_addr = 15'o00100;
        step();
        cpu_rd = 1'b0;
        dma_read_req = 1'b1; dma_ma = 15'o00101;
        settle();
        chk("t4 cpu_data_out", cpu_data_out, 12'o1111);
        step();
        chk("t4 pend ram_rd", ram_rd, 1'b1);
        chk("t4 pend ram_addr", ram_addr, 15'o00101);
        chk("t4 pend cpu_wait", cpu_wait, 1'b0);
        step();
        chk("t4 dma_done", dma_done, 1'b1);
        chk("t4 dma_data_out", dma_data_out, 12'o2222);
        chk("t4 done cpu_data_out", cpu_data_out, 12'o1111);
        dma_read_req = 1'b0;
        step();
        chk("t4 rec cpu_data_out", cpu_data_out, 12'o1111);
        chk("t4 rec dma_data_out", dma_data_out, 12'o2222);
        step();

        // Simultaneous read and write requests: the write is performed.
        dma_read_req = 1'b1; dma_write_req = 1'b1; dma_ma = 15'o00300; dma_data_in = 12'o4321;
        step();
        chk("t5 pend ram_wr", ram_wr, 1'b1);
        chk("t5 pend ram_rd", ram_rd, 1'b0);
        chk("t5 pend ram_addr", ram_addr, 15'o00300);
        step();
        chk("t5 dma_done", dma_done, 1'b1);
        chk("t5 dma_data_out unchanged", dma_data_out, 12'o2222);
        step();
        chk("t5 rec dma_done", dma_done, 1'b0);
        chk("t5 rec ram_wr", ram_wr, 1'b0);
        step();
        chk("t5 idle ram_wr", ram_wr, 1'b0);
        step();
        chk("t5 second pend ram_wr", ram_wr, 1'b1);
        dma_read_req = 1'b0; dma_write_req = 1'b0;
        step();
        chk("t5 second dma_done", dma_done, 1'b1);
        step();
        step();
        chk("t5 mem written", mem[15'o00300], 12'o4321);

        // Reset while a DMA write is pending behind CPU writes.
        cpu_wr = 1'b1; cpu_addr = 15'o00600; cpu_data_in = 12'o0246;
        dma_write_req = 1'b1; dma_ma = 15'o00500; dma_data_in = 12'o1357;
        step();
        chk("t6 pend cpu_wait", cpu_wait, 1'b0);
        chk("t6 pend ram_addr", ram_addr, 15'o00600);
        reset = 1'b1;
        settle();
        chk("t6 reset ram_wr", ram_wr, 1'b0);
        chk("t6 reset cpu_wait", cpu_wait, 1'b0);
        chk("t6 reset dma_done", dma_done, 1'b0);
        chk("t6 reset dma_data_out", dma_data_out, 12'o0000);
        chk("t6 reset cpu_data_out", cpu_data_out, 12'o0000);
        cpu_wr = 1'b0; dma_write_req = 1'b0;
        step();
        reset = 1'b0;
        settle();
        chk("t6 post dma_done", dma_done, 1'b0);
        chk("t6 dma target untouched", mem[15'o00500], 12'o0000);
        step();
        dma_read_req = 1'b1; dma_ma = 15'o17777;
        step();
        chk("t6 new pend ram_rd", ram_rd, 1'b1);
        chk("t6 new pend ram_addr", ram_addr, 15'o17777);
        step();
        chk("t6 new dma_done", dma_done, 1'b1);
        chk("t6 new dma_data_out", dma_data_out, 12'o7070);
        dma_read_req = 1'b0;
        step();
        step();

        // Randomized traffic: CPU on words 0..15, DMA on words 16..31.
        phase = 0; blocked = 0; last_dma = 12'o7070; prev_rd = 1'b0; prev_addr = 15'd0;
        hold = 1'b0; d_wr = 1'b0; d_addr = 15'd16; d_data = 12'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                case ($urandom_range(0, 3))
                    0:       begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
                    1, 2:    begin cpu_rd = 1'b1; cpu_wr = 1'b0; end
                    default: begin cpu_rd = 1'($urandom_range(0, 1)); cpu_wr = 1'b1; end
                endcase
                cpu_addr    = 15'($urandom_range(0, 15));
                cpu_data_in = 12'($urandom);
            end
            if (phase == 0 && cyc < 380 && $urandom_range(0, 2) == 0) begin
                d_wr          = 1'($urandom_range(0, 1));
                d_addr        = 15'($urandom_range(16, 31));
                d_data        = 12'($urandom);
                dma_ma        = d_addr;
                dma_data_in   = d_data;
                dma_write_req = d_wr;
                dma_read_req  = ~d_wr | 1'($urandom_range(0, 1));
                phase         = 1;
            end else if (phase == 4) begin
                dma_read_req  = 1'b0;
                dma_write_req = 1'b0;
            end
            settle();

            creq      = cpu_rd | cpu_wr;
            exp_grant = (phase == 2) && (!creq || blocked == MAXW);
            exp_wait  = exp_grant && creq;
            chk("rnd cpu_wait", cpu_wait, exp_wait);
            chk("rnd dma_done", dma_done, phase == 3);
            if (phase == 3 && !d_wr) last_dma = shadow[d_addr[4:0]];
            chk("rnd dma_data_out", dma_data_out, last_dma);
            if (exp_grant) begin
                chk("rnd dma ram_addr", ram_addr, d_addr);
                chk("rnd dma ram_wr", ram_wr, d_wr);
            end else begin
                chk("rnd cpu ram_addr", ram_addr, cpu_addr);
                chk("rnd cpu ram_wr", ram_wr, cpu_wr);
            end
            if (prev_rd) chk("rnd cpu_data_out", cpu_data_out, shadow[prev_addr[4:0]]);

            if (creq && !exp_wait && cpu_wr) shadow[cpu_addr[4:0]] = cpu_data_in;
            prev_rd   = creq && !exp_wait && !cpu_wr;
            prev_addr = cpu_addr;
            if (exp_grant && d_wr) shadow[d_addr[4:0]] = d_data;
            hold = exp_wait;
            case (phase)
                1: begin phase = 2; blocked = 0; end
                2: begin
                    if (exp_grant) phase = 3;
                    else blocked++;
                end
                3: phase = 4;
                4: phase = 0;
                default: phase = 0;
            endcase
            step();
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        dma_read_req = 1'b0; dma_write_req = 1'b0;
        step();
        step();
        for (int i = 0; i < 32; i++) begin
            chk("rnd final mem", mem[15'(i)], shadow[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
